// File: rtl/divisor_pkg.sv
// Shared constants and helpers for the DigitalPWM clock divider.
package divisor_pkg;

    // 100 MHz board clock down to a 50 kHz timebase.
    localparam int DIV_DEFAULT = 2000;

    // Ceiling log2 with a floor of 1 so a mod-2 counter still gets one bit.
    function automatic int clog2(input int value);
        int bits;
        longint pow;
        bits = 0;
        pow  = 1;
        while (pow < longint'(value)) begin
            pow  = pow << 1;
            bits = bits + 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/divisor_frecuencia_if.sv
// Observation bundle for the divider: live counter value and wrap flag.
interface divisor_frecuencia_if #(
    parameter int CNT_W = 11
);
    // No handshake: the counter free-runs, these are level signals sampled any time.
    logic [CNT_W-1:0] cnt;
    logic             wrap;

    modport master (output cnt, output wrap);
    modport slave  (input  cnt, input  wrap);
endinterface

// File: rtl/contador_mod_n.sv
// Mod-N up-counter with asynchronous active-high reset; exposes its next value
// so a sibling register can be loaded on the same edge.
module contador_mod_n #(
    parameter int N = 2000,
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_next,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         wrap_d;

    always_comb begin
        wrap_d = (cnt_q == LAST);
        cnt_d  = wrap_d ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt      = cnt_q;
    assign cnt_next = cnt_d;
    assign wrap     = wrap_d;

endmodule

// File: rtl/divisor_frecuencia.sv
// Integer clock divider: Clock_o is high while cnt >= floor(N/2), so odd ratios
// get the extra cycle in the high phase. Clock_o comes straight from a flop.
module divisor_frecuencia
    import divisor_pkg::*;
#(
    parameter int DIVISOR = DIV_DEFAULT,
    parameter int CNT_W   = clog2(DIVISOR)
) (
    input  logic                 Clock_i,
    input  logic                 reset_i,
    output logic                 Clock_o,
    divisor_frecuencia_if.master dbg
);

    localparam int               LOW_LEN = DIVISOR / 2;
    localparam logic [CNT_W-1:0] LOW_CMP = CNT_W'(LOW_LEN);

    if (DIVISOR < 2 || DIVISOR > (1 << 24)) begin : g_bad_divisor
        $error("divisor_frecuencia: DIVISOR must lie in [2, 2**24]");
    end

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             wrap;
    logic             clk_o_q;
    logic             clk_o_d;

    contador_mod_n #(
        .N (DIVISOR),
        .W (CNT_W)
    ) u_contador (
        .clk      (Clock_i),
        .rst      (reset_i),
        .cnt      (cnt),
        .cnt_next (cnt_next),
        .wrap     (wrap)
    );

    // Compare against the counter's next value so the output flop and the
    // counter update together and Clock_o always equals (cnt >= L).
    always_comb begin
        clk_o_d = (cnt_next >= LOW_CMP);
    end

    always_ff @(posedge Clock_i or posedge reset_i) begin
        if (reset_i) begin
            clk_o_q <= 1'b0;
        end else begin
            clk_o_q <= clk_o_d;
        end
    end

    assign Clock_o  = clk_o_q;
    assign dbg.cnt  = cnt;
    assign dbg.wrap = wrap;

endmodule

// File: tb/tb_divisor_frecuencia.sv
// Bench for divisor_frecuencia: four instances (N = 4, 5, 2, 2000) on one clock,
// each with its own reset, checked edge by edge against a phase model.
module tb_divisor_frecuencia;
    import divisor_pkg::*;

    localparam int W4  = clog2(4);
    localparam int W5  = clog2(5);
    localparam int W2  = clog2(2);
    localparam int W2K = clog2(DIV_DEFAULT);

    logic clk = 1'b0;
    logic rst4 = 1'b0, rst5 = 1'b0, rst2 = 1'b0, rst2k = 1'b0;
    logic co4, co5, co2, co2k;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    divisor_frecuencia_if #(.CNT_W(W4))  if4  ();
    divisor_frecuencia_if #(.CNT_W(W5))  if5  ();
    divisor_frecuencia_if #(.CNT_W(W2))  if2  ();
    divisor_frecuencia_if #(.CNT_W(W2K)) if2k ();

    divisor_frecuencia #(.DIVISOR(4)) dut4 (
        .Clock_i(clk), .reset_i(rst4), .Clock_o(co4), .dbg(if4));
    divisor_frecuencia #(.DIVISOR(5)) dut5 (
        .Clock_i(clk), .reset_i(rst5), .Clock_o(co5), .dbg(if5));
    divisor_frecuencia #(.DIVISOR(2)) dut2 (
        .Clock_i(clk), .reset_i(rst2), .Clock_o(co2), .dbg(if2));
    divisor_frecuencia #(.DIVISOR(DIV_DEFAULT)) dut2k (
        .Clock_i(clk), .reset_i(rst2k), .Clock_o(co2k), .dbg(if2k));

    // 10 ns clock
    always #5 clk = ~clk;

    // Packs {cnt, Clock_o} of the selected instance as cnt*2 + Clock_o.
    function automatic logic [31:0] sample(input int which);
        case (which)
            0:       return (32'(if4.cnt)  << 1) | 32'(co4);
            1:       return (32'(if5.cnt)  << 1) | 32'(co5);
            2:       return (32'(if2.cnt)  << 1) | 32'(co2);
            default: return (32'(if2k.cnt) << 1) | 32'(co2k);
        endcase
    endfunction

    // Model: after k edges since release, phase = k mod n, high when phase >= n/2.
    task automatic push_expected(input int n, input int edges);
        for (int k = 1; k <= edges; k++) begin
            int ph;
            ph = k % n;
            exp_q.push_back((32'(ph) << 1) | ((ph >= n / 2) ? 32'd1 : 32'd0));
        end
    endtask

    task automatic test_reset();
        rst4 = 1'b1; rst5 = 1'b1; rst2 = 1'b1; rst2k = 1'b1;
        #1;
        for (int w = 0; w < 4; w++) begin
            checks++;
            if (sample(w) !== 32'd0) begin
                errors++;
                $display("FAIL reset_immediate dut%0d: got cnt=%0d clk=%0b, expected cnt=0 clk=0",
                         w, sample(w) >> 1, sample(w) & 1);
            end
        end
        // hold reset for 100 ns with the clock running
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int w = 0; w < 4; w++) begin
                checks++;
                if (sample(w) !== 32'd0) begin
                    errors++;
                    $display("FAIL reset_held dut%0d cyc%0d: got cnt=%0d clk=%0b, expected cnt=0 clk=0",
                             w, c, sample(w) >> 1, sample(w) & 1);
                end
            end
        end
    endtask

    task automatic test_even();
        logic [31:0] exp, got;
        @(negedge clk);
        rst4 = 1'b0;
        push_expected(4, 80);
        for (int e = 1; exp_q.size() > 0; e++) begin
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            got = sample(0);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL even_n4 edge%0d: got cnt=%0d clk=%0b, expected cnt=%0d clk=%0b",
                         e, got >> 1, got & 1, exp >> 1, exp & 1);
            end
        end
    endtask

    task automatic test_odd();
        logic [31:0] exp, got;
        @(negedge clk);
        rst5 = 1'b0;
        push_expected(5, 50);
        for (int e = 1; exp_q.size() > 0; e++) begin
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            got = sample(1);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL odd_n5 edge%0d: got cnt=%0d clk=%0b, expected cnt=%0d clk=%0b",
                         e, got >> 1, got & 1, exp >> 1, exp & 1);
            end
        end
    endtask

    task automatic test_min();
        logic [31:0] exp, got;
        @(negedge clk);
        rst2 = 1'b0;
        push_expected(2, 20);
        for (int e = 1; exp_q.size() > 0; e++) begin
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            got = sample(2);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL min_n2 edge%0d: got cnt=%0d clk=%0b, expected cnt=%0d clk=%0b",
                         e, got >> 1, got & 1, exp >> 1, exp & 1);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] exp, got;
        @(negedge clk);
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        got = sample(0);
        checks++;
        if (got !== 32'd5) begin
            errors++;
            $display("FAIL async_pre_high: got cnt=%0d clk=%0b, expected cnt=2 clk=1", got >> 1, got & 1);
        end
        // assert between edges while Clock_o is high
        rst4 = 1'b1;
        #1;
        got = sample(0);
        checks++;
        if (got !== 32'd0) begin
            errors++;
            $display("FAIL async_drop: got cnt=%0d clk=%0b, expected cnt=0 clk=0", got >> 1, got & 1);
        end
        @(posedge clk); #1;
        got = sample(0);
        checks++;
        if (got !== 32'd0) begin
            errors++;
            $display("FAIL async_held: got cnt=%0d clk=%0b, expected cnt=0 clk=0", got >> 1, got & 1);
        end
        @(negedge clk);
        rst4 = 1'b0;
        push_expected(4, 12);
        for (int e = 1; exp_q.size() > 0; e++) begin
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            got = sample(0);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL async_restart edge%0d: got cnt=%0d clk=%0b, expected cnt=%0d clk=%0b",
                         e, got >> 1, got & 1, exp >> 1, exp & 1);
            end
        end
    endtask

    task automatic test_default();
        logic [31:0] exp, got;
        int high_cnt;
        high_cnt = 0;
        @(negedge clk);
        rst2k = 1'b0;
        push_expected(DIV_DEFAULT, 2 * DIV_DEFAULT);
        for (int e = 1; exp_q.size() > 0; e++) begin
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            got = sample(3);
            if (got[0]) high_cnt++;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL default_n2000 edge%0d: got cnt=%0d clk=%0b, expected cnt=%0d clk=%0b",
                         e, got >> 1, got & 1, exp >> 1, exp & 1);
            end
        end
        // two full periods: 2 x 1000 high cycles
        checks++;
        if (high_cnt !== 2 * (DIV_DEFAULT - DIV_DEFAULT / 2)) begin
            errors++;
            $display("FAIL default_high_time: got %0d high cycles, expected %0d",
                     high_cnt, 2 * (DIV_DEFAULT - DIV_DEFAULT / 2));
        end
    endtask

    initial begin
        test_reset();
        test_even();
        test_odd();
        test_min();
        test_async_reset();
        test_default();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
